button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
Upstream input stage for the push-button control FSMs on the board.
- Synchronises the raw pin and rejects bounce with per-edge stability windows.
- Emits clean one-cycle press/release pulses plus a debounced level.
- Emits an auto-repeat hold pulse, a wrap-around press counter and a state code for LED/segment debug.
- Downstream FSMs consume these outputs instead of sampling the pin themselves.

Parameters:
DEBOUNCE_CYCLES, 1000000, stable-level window in clk cycles (20 ms at 50 MHz); must be >= 1
HOLD_CYCLES, 50000000, cycles pressed before first hold_pulse (1 s at 50 MHz); must be >= 1
REPEAT_CYCLES, 12500000, period of hold_pulse after the first one; 0 = single hold_pulse only
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (board default), 0 = active-high pin
CNT_W, 32, width of the internal debounce/hold/repeat counters

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  reset; synchronous, active-high
button  input  1  raw asynchronous pin
btn_level  output  1  debounced pressed level, 1 = pressed
press_pulse  output  1  one-cycle pulse on a confirmed press
release_pulse  output  1  one-cycle pulse on a confirmed release
hold_pulse  output  1  one-cycle pulse on long press and on each auto-repeat
press_count  output  8  confirmed presses, modulo 256
dbg_state  output  2  current FSM state encoding

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - all outputs 0; FSM in IDLE; all counters 0.
  - Both synchroniser flops load the idle pin level: 1 if ACTIVE_LOW, else 0.
- Synchroniser: 2 flops, then normalise to pressed_raw (inverted if ACTIVE_LOW).
- FSM states, encoded in dbg_state: IDLE=0, PRESS_CHK=1, HELD=2, RELEASE_CHK=3.
- IDLE:
  - pressed_raw=1 -> PRESS_CHK, deb_cnt cleared.
- PRESS_CHK:
  - pressed_raw=0 -> IDLE (glitch rejected, no pulse).
  - pressed_raw=1: deb_cnt increments.
  - Edge with deb_cnt==DEBOUNCE_CYCLES-1 -> HELD. press_pulse=1, btn_level=1 and press_count+1 all appear in the first HELD cycle.
- Press latency: press_pulse is visible after the (DEBOUNCE_CYCLES+3)th rising edge, counting from the first edge that samples the pressed pin.
- HELD:
  - Let P = first HELD cycle; hold_cnt=0 in P.
  - hold_pulse first high in cycle P+HOLD_CYCLES, then every REPEAT_CYCLES while held (if REPEAT_CYCLES>0).
  - pressed_raw=0 -> RELEASE_CHK, deb_cnt cleared.
- RELEASE_CHK:
  - pressed_raw=1 -> HELD (bounce). No press_pulse; hold/repeat counters resume from their frozen values.
  - pressed_raw=0 for DEBOUNCE_CYCLES consecutive edges -> IDLE. release_pulse=1 and btn_level=0 appear in the first IDLE cycle.
  - Hold/repeat counters are frozen and no hold_pulse is emitted in this state. Counters are cleared on entry to IDLE.
- Pulse rules:
  - press_pulse, release_pulse and hold_pulse are never high for more than 1 cycle each.
  - press_pulse and release_pulse are never high together.
  - hold_pulse is never coincident with press_pulse.
- press_count: 255 + press -> 0 (wrap-around, no saturation).
- Counter widths: compare counters against parameters at CNT_W bits. Parameters must fit in CNT_W; an elaboration-time assertion checks this.
- Reset mid-operation:
  - Any state -> IDLE next cycle; outputs drop to 0 with no release_pulse.
  - If the pin is still pressed when rst deasserts, a fresh press is detected with full latency.

Decomposition:
- Package btn_pkg:
  - btn_state_t enum with the explicit 2-bit encodings above.
  - Default timing constants for 50 MHz (DEB_20MS, HOLD_1S, REP_250MS).
- Sub-module sync_2ff:
  - Parameter RESET_VAL; ports clk, rst, d, q.
  - Reused for any other async board input.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5, ACTIVE_LOW=1.)
1. Clean press: button 1->0, held 20 cycles -> press_pulse for 1 cycle after 7th edge; btn_level=1; dbg_state=2; press_count=1.
2. Glitch: button low 3 cycles, then high -> no pulses; dbg_state returns to 0; press_count unchanged.
3. Release bounce: from HELD, button high 2, low 2, high 10 -> exactly one release_pulse; no extra press_pulse; btn_level=0 at the end.
4. Hold/repeat: keep pressed 31 cycles after press_pulse cycle P -> hold_pulse at P+10, P+15, P+20, P+25, P+30 only.
5. Wrap: 256 clean press/release sequences from reset -> press_count reads 255 after the 255th press and 0 after the 256th.
6. Reset mid-hold: rst=1 for 1 cycle while HELD with button low -> next cycle all outputs 0, dbg_state=0; button kept low -> press_pulse 7 edges after rst deasserts.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button input stage.
package btn_pkg;

    // Encodings are exported on dbg_state, so they are pinned explicitly.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_t;

    // Default timing for a 50 MHz system clock.
    localparam int unsigned DEB_20MS  = 32'd1_000_000;
    localparam int unsigned HOLD_1S   = 32'd50_000_000;
    localparam int unsigned REP_250MS = 32'd12_500_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs.
// RESET_VAL should be the idle level of the pin so reset never fakes an edge.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the async input; both stages load the idle level on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronise, debounce both edges, and produce
// press/release/hold pulses, a debounced level, a press counter and a
// debug state code for downstream control FSMs.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEB_20MS,
    parameter int unsigned HOLD_CYCLES     = HOLD_1S,
    parameter int unsigned REPEAT_CYCLES   = REP_250MS,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       hold_pulse,
    output logic [7:0] press_count,
    output logic [1:0] dbg_state
);

    // Terminal counts; counters run from 0 so the last value is N-1.
    // With REPEAT_CYCLES == 0 REP_LAST wraps, but it is never consulted then.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic             IDLE_PIN  = ACTIVE_LOW;

    // Parameter sanity: windows must be non-empty and fit the counter width.
    generate
        if (CNT_W == 0 || CNT_W > 32) begin : g_chk_cnt_w
            $error("button_conditioner: CNT_W must be 1..32");
        end
        if (DEBOUNCE_CYCLES == 0) begin : g_chk_deb_min
            $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
        end
        if (HOLD_CYCLES == 0) begin : g_chk_hold_min
            $error("button_conditioner: HOLD_CYCLES must be >= 1");
        end
        if ((64'(DEBOUNCE_CYCLES) >> CNT_W) != 64'd0) begin : g_chk_deb_fit
            $error("button_conditioner: DEBOUNCE_CYCLES does not fit in CNT_W");
        end
        if ((64'(HOLD_CYCLES) >> CNT_W) != 64'd0) begin : g_chk_hold_fit
            $error("button_conditioner: HOLD_CYCLES does not fit in CNT_W");
        end
        if ((64'(REPEAT_CYCLES) >> CNT_W) != 64'd0) begin : g_chk_rep_fit
            $error("button_conditioner: REPEAT_CYCLES does not fit in CNT_W");
        end
    endgenerate

    logic             pin_sync;
    logic             pressed_raw;
    btn_state_t       state;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] rep_cnt;
    logic             hold_done;

    sync_2ff #(
        .RESET_VAL (IDLE_PIN)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (button),
        .q   (pin_sync)
    );

    // Normalise polarity so 1 always means "pressed" from here on.
    assign pressed_raw = pin_sync ^ ACTIVE_LOW;
    assign dbg_state   = state;

    // Debounce/hold FSM; every output is set here so all of them are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            hold_done     <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pressed_raw) begin
                        state   <= PRESS_CHK;
                        deb_cnt <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!pressed_raw) begin
                        // Too short to be a press: drop it silently.
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state       <= HELD;
                        press_pulse <= 1'b1;
                        btn_level   <= 1'b1;
                        press_count <= press_count + 8'd1;
                        hold_cnt    <= '0;
                        rep_cnt     <= '0;
                        hold_done   <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!pressed_raw) begin
                        // Hold/repeat counters freeze until the release is confirmed or bounces back.
                        state   <= RELEASE_CHK;
                        deb_cnt <= '0;
                    end else if (!hold_done) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_pulse <= 1'b1;
                            hold_done  <= 1'b1;
                            rep_cnt    <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + CNT_ONE;
                        end
                    end else if (REPEAT_CYCLES != 0) begin
                        if (rep_cnt == REP_LAST) begin
                            hold_pulse <= 1'b1;
                            rep_cnt    <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + CNT_ONE;
                        end
                    end
                end
                RELEASE_CHK: begin
                    if (pressed_raw) begin
                        state <= HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        btn_level     <= 1'b0;
                        deb_cnt       <= '0;
                        hold_cnt      <= '0;
                        rep_cnt       <= '0;
                        hold_done     <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

endmodule
